s_machine_core: RTL

Parametrised successor of the S-Machine CPU top. It merges the instruction interpreter and the run-control state machine into one clocked accumulator core, generalised in data and address width. Unlike the first generation, it uses ready/valid handshakes on instruction fetch and data memory, so wait states are tolerated. It adds a halt instruction, a sticky illegal-opcode flag and a retired-instruction counter, and sits between the instruction ROM and the data RAM in the top level.

---
 rtl/s_machine_core.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/s_machine_core.sv
// Accumulator core with ready/valid instruction fetch and data memory ports.
// Run control and instruction execution share one FSM: IDLE, FETCH, DECODE, MEM, EXEC, HALT.
module s_machine_core #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_valid,
   input  logic [DATA_W-1:0] inst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] acc,
   output logic              halted,
   output logic              illegal,
   output logic [CNT_W-1:0]  count
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM    = 3'd3,
      ST_EXEC   = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_LDI   = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_STORE = 4'd3;
   localparam logic [3:0] OP_ADD   = 4'd4;
   localparam logic [3:0] OP_SUB   = 4'd5;
   localparam logic [3:0] OP_JMP   = 4'd6;
   localparam logic [3:0] OP_JZ    = 4'd7;
   localparam logic [3:0] OP_HALT  = 4'd8;

   state_t              state_r;
   state_t              state_s;
   logic [DATA_W-1:0]   ir_r;
   logic [DATA_W-1:0]   acc_r;
   logic [DATA_W-1:0]   mdr_r;
   logic [ADDR_W-1:0]   pc_r;
   logic [CNT_W-1:0]    count_r;
   logic                illegal_r;
   logic [3:0]          op_s;
   logic [ADDR_W-1:0]   k_s;
   logic [ADDR_W-1:0]   pc_inc_s;
   logic                is_mem_s;
   logic                ir_unused_s;

   assign op_s        = ir_r[DATA_W-1 -: 4];
   assign k_s         = ir_r[ADDR_W-1:0];
   assign pc_inc_s    = pc_r + ADDR_W'(1);
   assign is_mem_s    = (op_s == OP_LOAD) || (op_s == OP_STORE) ||
                        (op_s == OP_ADD)  || (op_s == OP_SUB);
   // Bits between the opcode and the operand field carry no meaning.
   assign ir_unused_s = ^ir_r;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; enable is only consulted in IDLE and at the end of EXEC.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) state_s = ST_FETCH;
            else        state_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (inst_valid) state_s = ST_DECODE;
            else            state_s = ST_FETCH;
         end
         ST_DECODE: begin
            if (is_mem_s) state_s = ST_MEM;
            else          state_s = ST_EXEC;
         end
         ST_MEM: begin
            if (mem_ready) state_s = ST_EXEC;
            else           state_s = ST_MEM;
         end
         ST_EXEC: begin
            if (op_s == OP_HALT) state_s = ST_HALT;
            else if (enable)     state_s = ST_FETCH;
            else                 state_s = ST_IDLE;
         end
         ST_HALT: state_s = ST_HALT;
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath: instruction latch, memory holding register and retirement in EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_r      <= {DATA_W{1'b0}};
         acc_r     <= {DATA_W{1'b0}};
         mdr_r     <= {DATA_W{1'b0}};
         pc_r      <= {ADDR_W{1'b0}};
         count_r   <= {CNT_W{1'b0}};
         illegal_r <= 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (inst_valid) ir_r <= inst;
            end
            ST_MEM: begin
               if (mem_ready) mdr_r <= mem_rdata;
            end
            ST_EXEC: begin
               count_r <= count_r + CNT_W'(1);
               pc_r    <= pc_inc_s;
               case (op_s)
                  OP_NOP, OP_STORE, OP_HALT: ;
                  OP_LDI:  acc_r <= DATA_W'(k_s);
                  OP_LOAD: acc_r <= mdr_r;
                  OP_ADD:  acc_r <= acc_r + mdr_r;
                  OP_SUB:  acc_r <= acc_r - mdr_r;
                  OP_JMP:  pc_r  <= k_s;
                  OP_JZ: begin
                     if (acc_r == {DATA_W{1'b0}}) pc_r <= k_s;
                  end
                  default: illegal_r <= 1'b1;
               endcase
            end
            default: ;
         endcase
      end
   end

   // Handshake outputs come from state and registers only, so reset drops them at once.
   assign inst_req  = (state_r == ST_FETCH);
   assign inst_addr = pc_r;
   assign mem_req   = (state_r == ST_MEM);
   assign mem_we    = (state_r == ST_MEM) && (op_s == OP_STORE);
   assign mem_addr  = k_s;
   assign mem_wdata = acc_r;
   assign pc        = pc_r;
   assign acc       = acc_r;
   assign halted    = (state_r == ST_HALT);
   assign illegal   = illegal_r;
   assign count     = count_r;

endmodule
